// File: rtl/usbdev_aon_resume_tx.sv
// Always-on USB remote-wakeup transmitter: after a remote-wake request, waits
// for the bus-idle interval, drives resume K for a fixed interval, then releases the bus.
module usbdev_aon_resume_tx #(
    parameter int unsigned IdleCycles   = 1000,
    parameter int unsigned ResumeCycles = 2000
) (
    input  logic clk_aon_i,
    input  logic rst_aon_ni,
    input  logic wake_detect_active_aon_i,
    input  logic bus_not_idle_aon_i,
    input  logic remote_wake_req_aon_i,
    input  logic pinflip_aon_i,
    output logic usb_oe_o,
    output logic usb_dp_o,
    output logic usb_dn_o,
    output logic resume_active_aon_o,
    output logic resume_done_aon_o,
    output logic resume_abort_aon_o
);

    localparam int unsigned MaxCycles = (IdleCycles > ResumeCycles) ? IdleCycles : ResumeCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] IdleLast   = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] ResumeLast = CntW'(ResumeCycles - 1);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitIdle = 2'd1,
        StDrive    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_q;
    logic            start;
    logic            done_evt, abort_evt;
    logic            done_evt_q, abort_evt_q;

    logic oe_q, dp_q, dn_q, active_q, done_q, abort_q;

    assign start = remote_wake_req_aon_i & ~req_q;

    always_comb begin
        state_d   = state_q;
        done_evt  = 1'b0;
        abort_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A request while not suspended or with host activity is simply dropped.
                if (start && wake_detect_active_aon_i && !bus_not_idle_aon_i) begin
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (!wake_detect_active_aon_i || bus_not_idle_aon_i) begin
                    state_d   = StIdle;
                    abort_evt = 1'b1;
                end else if (cnt_q == IdleLast) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                // Host activity is ignored here: our own K state trips the detector.
                if (!wake_detect_active_aon_i) begin
                    state_d   = StIdle;
                    abort_evt = 1'b1;
                end else if (cnt_q == ResumeLast) begin
                    state_d  = StIdle;
                    done_evt = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (state_d != state_q || state_q == StIdle) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            done_evt_q  <= 1'b0;
            abort_evt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= remote_wake_req_aon_i;
            done_evt_q  <= done_evt;
            abort_evt_q <= abort_evt;
        end
    end

    // Output stage lags the state by one cycle so the pulses line up with oe release.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            oe_q     <= 1'b0;
            dp_q     <= 1'b0;
            dn_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            oe_q     <= (state_q == StDrive);
            dp_q     <= (state_q == StDrive) &  pinflip_aon_i;
            dn_q     <= (state_q == StDrive) & ~pinflip_aon_i;
            active_q <= (state_q != StIdle);
            done_q   <= done_evt_q;
            abort_q  <= abort_evt_q;
        end
    end

    assign usb_oe_o            = oe_q;
    assign usb_dp_o            = dp_q;
    assign usb_dn_o            = dn_q;
    assign resume_active_aon_o = active_q;
    assign resume_done_aon_o   = done_q;
    assign resume_abort_aon_o  = abort_q;

endmodule

// File: tb/tb_usbdev_aon_resume_tx.sv
// Bench for usbdev_aon_resume_tx: scenario table, hand-written reset/hold
// sequences and random stimulus, all checked cycle by cycle against a timeline model.
module tb_usbdev_aon_resume_tx;

    localparam int IDLE = 10;
    localparam int RES  = 20;

    logic clk_aon_i = 1'b0;
    logic rst_aon_ni;
    logic wake_detect_active_aon_i;
    logic bus_not_idle_aon_i;
    logic remote_wake_req_aon_i;
    logic pinflip_aon_i;
    logic usb_oe_o, usb_dp_o, usb_dn_o;
    logic resume_active_aon_o, resume_done_aon_o, resume_abort_aon_o;

    always #5 clk_aon_i = ~clk_aon_i;

    usbdev_aon_resume_tx #(
        .IdleCycles   (IDLE),
        .ResumeCycles (RES)
    ) dut (
        .clk_aon_i                (clk_aon_i),
        .rst_aon_ni               (rst_aon_ni),
        .wake_detect_active_aon_i (wake_detect_active_aon_i),
        .bus_not_idle_aon_i       (bus_not_idle_aon_i),
        .remote_wake_req_aon_i    (remote_wake_req_aon_i),
        .pinflip_aon_i            (pinflip_aon_i),
        .usb_oe_o                 (usb_oe_o),
        .usb_dp_o                 (usb_dp_o),
        .usb_dn_o                 (usb_dn_o),
        .resume_active_aon_o      (resume_active_aon_o),
        .resume_done_aon_o        (resume_done_aon_o),
        .resume_abort_aon_o       (resume_abort_aon_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Timeline model: a sequence started at edge t0 waits while (k - t0) < IDLE,
    // drives K while IDLE <= (k - t0) < IDLE + RES; outputs show up one edge later.
    bit m_busy     = 0;
    int m_t0       = 0;
    int m_k        = 0;
    bit m_prev_req = 0;
    bit e_active = 0, e_oe = 0, e_done = 0, e_abort = 0;

    int n_oe, n_dp, n_dn, n_done, n_abort;

    typedef struct {
        string name;
        bit    pf;
        bit    wa0;
        bit    bni0;
        int    bni_at;
        int    wa_drop_at;
        int    exp_oe;
        int    exp_done;
        int    exp_abort;
    } vec_t;

    vec_t vecs [8];

    task automatic model_reset();
        m_busy     = 0;
        m_prev_req = 0;
        e_active   = 0;
        e_oe       = 0;
        e_done     = 0;
        e_abort    = 0;
    endtask

    task automatic model_update();
        bit nd;
        bit na;
        int el;
        nd = 0;
        na = 0;
        if (!rst_aon_ni) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            if (remote_wake_req_aon_i && !m_prev_req && wake_detect_active_aon_i && !bus_not_idle_aon_i) begin
                m_busy = 1;
                m_t0   = m_k;
            end
        end else begin
            el = m_k - m_t0;
            if (!wake_detect_active_aon_i) begin
                m_busy = 0;
                na     = 1;
            end else if (el <= IDLE && bus_not_idle_aon_i) begin
                m_busy = 0;
                na     = 1;
            end else if (el == IDLE + RES) begin
                m_busy = 0;
                nd     = 1;
            end
        end
        m_prev_req = remote_wake_req_aon_i;
        e_active   = m_busy;
        e_oe       = m_busy && ((m_k - m_t0) >= IDLE);
        e_done     = nd;
        e_abort    = na;
    endtask

    task automatic check_outputs(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {resume_active_aon_o, usb_oe_o, usb_dp_o, usb_dn_o, resume_done_aon_o, resume_abort_aon_o};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s edge %0d: {active,oe,dp,dn,done,abort} got %b expected %b", name, m_k, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_counts();
        n_oe = 0; n_dp = 0; n_dn = 0; n_done = 0; n_abort = 0;
    endtask

    // One clock: compare against the expectation formed at the previous edge, then advance the model.
    task automatic step();
        bit xoe;
        @(posedge clk_aon_i);
        #1;
        m_k++;
        xoe = e_oe;
        check_outputs("cycle", {e_active, xoe, xoe & pinflip_aon_i, xoe & ~pinflip_aon_i, e_done, e_abort});
        n_oe    += int'(usb_oe_o);
        n_dp    += int'(usb_dp_o);
        n_dn    += int'(usb_dn_o);
        n_done  += int'(resume_done_aon_o);
        n_abort += int'(resume_abort_aon_o);
        model_update();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_vec(input vec_t v);
        pinflip_aon_i            = v.pf;
        wake_detect_active_aon_i = v.wa0;
        bus_not_idle_aon_i       = v.bni0;
        remote_wake_req_aon_i    = 1'b0;
        steps(2);
        remote_wake_req_aon_i = 1'b1;
        step();
        clear_counts();
        for (int i = 1; i <= 45; i++) begin
            if (i == v.bni_at)     bus_not_idle_aon_i       = 1'b1;
            if (i == v.wa_drop_at) wake_detect_active_aon_i = 1'b0;
            step();
        end
        check_int({v.name, " oe cycles"}, n_oe, v.exp_oe);
        check_int({v.name, " dp cycles"}, n_dp, v.pf ? v.exp_oe : 0);
        check_int({v.name, " dn cycles"}, n_dn, v.pf ? 0 : v.exp_oe);
        check_int({v.name, " done pulses"}, n_done, v.exp_done);
        check_int({v.name, " abort pulses"}, n_abort, v.exp_abort);
        $display("vec %-14s oe=%0d dp=%0d dn=%0d done=%0d abort=%0d", v.name, n_oe, n_dp, n_dn, n_done, n_abort);
        remote_wake_req_aon_i    = 1'b0;
        bus_not_idle_aon_i       = 1'b0;
        wake_detect_active_aon_i = 1'b1;
        steps(3);
    endtask

    initial begin
        vecs[0] = '{"normal",         1'b0, 1'b1, 1'b0, -1, -1, 20, 1, 0};
        vecs[1] = '{"pinflip",        1'b1, 1'b1, 1'b0, -1, -1, 20, 1, 0};
        vecs[2] = '{"bni_wait5",      1'b0, 1'b1, 1'b0,  5, -1,  0, 0, 1};
        vecs[3] = '{"bni_in_drive",   1'b0, 1'b1, 1'b0, 15, -1, 20, 1, 0};
        vecs[4] = '{"wa_drop_drive7", 1'b1, 1'b1, 1'b0, -1, 17,  7, 0, 1};
        vecs[5] = '{"wa_drop_last",   1'b0, 1'b1, 1'b0, -1, 30, 20, 0, 1};
        vecs[6] = '{"inactive",       1'b0, 1'b0, 1'b0, -1, -1,  0, 0, 0};
        vecs[7] = '{"bus_busy",       1'b0, 1'b1, 1'b1, -1, -1,  0, 0, 0};

        rst_aon_ni               = 1'b0;
        wake_detect_active_aon_i = 1'b1;
        bus_not_idle_aon_i       = 1'b0;
        remote_wake_req_aon_i    = 1'b0;
        pinflip_aon_i            = 1'b0;
        #1;
        check_outputs("reset_state", 6'b0);
        steps(2);
        rst_aon_ni = 1'b1;
        steps(2);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Request held high well past completion must not start a second sequence.
        pinflip_aon_i         = 1'b1;
        remote_wake_req_aon_i = 1'b1;
        step();
        clear_counts();
        steps(IDLE + RES + 105);
        check_int("held_req oe cycles", n_oe, RES);
        check_int("held_req done pulses", n_done, 1);
        $display("seq held_req      oe=%0d done=%0d abort=%0d", n_oe, n_done, n_abort);
        remote_wake_req_aon_i = 1'b0;
        pinflip_aon_i         = 1'b0;
        steps(2);

        // Reset in the middle of Drive: outputs clear without waiting for a clock.
        remote_wake_req_aon_i = 1'b1;
        step();
        steps(15);
        check_int("pre_reset oe", int'(usb_oe_o), 1);
        #2;
        rst_aon_ni = 1'b0;
        #1;
        check_outputs("async_reset", 6'b0);
        model_reset();
        clear_counts();
        steps(2);
        remote_wake_req_aon_i = 1'b0;
        rst_aon_ni            = 1'b1;
        steps(5);
        check_int("post_reset pulses", n_done + n_abort, 0);
        remote_wake_req_aon_i = 1'b1;
        step();
        clear_counts();
        steps(IDLE + RES + 5);
        check_int("post_reset done pulses", n_done, 1);
        $display("seq reset_mid_drive recovered: oe=%0d done=%0d", n_oe, n_done);
        remote_wake_req_aon_i = 1'b0;
        steps(2);

        // Random traffic against the timeline model.
        clear_counts();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) remote_wake_req_aon_i = ~remote_wake_req_aon_i;
            if (wake_detect_active_aon_i) begin
                if ($urandom_range(0, 299) == 0) wake_detect_active_aon_i = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                wake_detect_active_aon_i = 1'b1;
            end
            if ($urandom_range(0, 79) == 0) bus_not_idle_aon_i = 1'b1;
            else if (bus_not_idle_aon_i && $urandom_range(0, 4) == 0) bus_not_idle_aon_i = 1'b0;
            if (!m_busy && $urandom_range(0, 49) == 0) pinflip_aon_i = ~pinflip_aon_i;
            step();
        end
        $display("seq random        oe=%0d done=%0d abort=%0d", n_oe, n_done, n_abort);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
